// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one cache read at a time and queues {pc, instr} for decode.
// Optional build macro FETCH_PERF_COUNTERS_EN adds fetch_count/stall_count outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        read_request,
  output logic [31:0] addr,
  input  logic        read_response,
  input  logic [31:0] read_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_t;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      addr_q;
  logic             req_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic [31:0] data_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic        room;
  logic [31:0] pc_inc;
  logic [31:0] target_aligned;

  assign read_request = req_q;
  assign addr         = addr_q;
  assign instr_valid  = (count_q != '0);
  assign instr_data   = instr_valid ? data_mem[rd_ptr_q] : 32'h0;
  assign instr_pc     = instr_valid ? pc_mem[rd_ptr_q]   : 32'h0;

  // A redirect kills both the push and the pop of its cycle.
  always_comb begin
    push           = read_response && (state_q == S_REQ) && !branch_taken;
    pop            = instr_valid && instr_ready && !branch_taken;
    count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
    room           = (count_d < DEPTH_C);
    pc_inc         = pc_q + 32'd4;
    target_aligned = branch_target & ~32'd3;
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[wr_ptr_q] <= read_data;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR;
      addr_q   <= RESET_VECTOR;
      req_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (branch_taken) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= target_aligned;
      // An unanswered read must still complete on the cache side, so it is drained in DISCARD.
      case (state_q)
        S_REQ, S_DISCARD: begin
          if (read_response) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end else begin
            state_q <= S_DISCARD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      case (state_q)
        S_IDLE: begin
          if (room) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        S_REQ: begin
          if (read_response) begin
            pc_q <= pc_inc;
            if (room) begin
              addr_q <= pc_inc;
            end else begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (read_response) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      if (push)                   fetch_count_q <= fetch_count_q + 32'd1;
      if (req_q && !read_response) stall_count_q <= stall_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction cache.
- Owns the program counter and issues word reads to the cache with a request/response handshake, at most one read outstanding.
- Buffers returned instructions, with their PCs, in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects: flushes the FIFO and discards any in-flight cache response.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- branch_taken  input  1  redirect request from execute; one-cycle pulse.
- branch_target  input  32  redirect PC; bits [1:0] ignored and forced to 0.
- read_request  output  1  to cache: read request, held until read_response.
- addr  output  32  to cache: word address; stable while read_request is high.
- read_response  input  1  from cache: one-cycle pulse, read_data valid.
- read_data  input  32  from cache: instruction word.
- instr_valid  output  1  to decode: FIFO head valid.
- instr_data  output  32  to decode: instruction at FIFO head.
- instr_pc  output  32  to decode: PC of the FIFO head instruction.
- instr_ready  input  1  from decode: head consumed when instr_valid and instr_ready are both high.

Behaviour:
- Reset, synchronous:
  - pc=RESET_VECTOR, FIFO empty (count=0, pointers 0), state IDLE.
  - read_request=0, addr=RESET_VECTOR, instr_valid=0, instr_data=0, instr_pc=0.
  - Reset overrides every other input in the same cycle.
- read_request and addr are registered outputs.
- instr_valid, instr_data and instr_pc are driven combinationally from the FIFO head; instr_valid=(count!=0).
- count_next = count + push - pop, where:
  - push = read_response accepted in state REQ with no flush.
  - pop = instr_valid & instr_ready with no flush.
- Free-slot rule:
  - A new request may be issued only if count_next < FIFO_DEPTH.
  - Because only one read is ever outstanding, a response always has room and the FIFO never overflows.
- States:
  - IDLE: read_request=0. If no flush and count_next<FIFO_DEPTH, go to REQ with read_request=1 and addr=pc.
  - REQ: read_request=1 and addr=pc, held until read_response. On read_response:
    - push {pc, read_data}; pc<=pc+4.
    - If count_next<FIFO_DEPTH, stay in REQ with addr=pc+4 (back-to-back, zero bubble).
    - Otherwise go to IDLE with read_request=0.
  - DISCARD: read_request stays 1 with the stale addr (the cache handshake is not abandoned). On read_response, data is dropped and the unit goes to IDLE; nothing is pushed and pc is unchanged.
- Redirect (branch_taken=1), highest priority after reset:
  - FIFO emptied and pc<=branch_target&~3; any pop in that cycle is lost.
  - From REQ without read_response in the same cycle: go to DISCARD.
  - From REQ with read_response in the same cycle: data dropped, go to IDLE.
  - From IDLE: go to IDLE.
  - From DISCARD: stay in DISCARD, pc updated to the newer target.
  - The first request to the target is issued on the cycle after the unit reaches IDLE.
- Best-case latency: from reset release, the first request is visible one cycle later.
- PC arithmetic is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4=0).
- FIFO full, empty and simultaneous cases:
  - Full FIFO with decode stalled: no request is issued.
  - Simultaneous push and pop: count unchanged.
  - Simultaneous push and pop on an empty FIFO: the pushed entry appears the next cycle (no bypass).

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined:
  - Two extra outputs: fetch_count[31:0], incremented on every push; and stall_count[31:0], incremented each cycle that read_request=1 and read_response=0.
  - Both reset to 0, wrap at 2^32 and are not cleared by branch_taken.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, cache responding 1 cycle after each request, instr_ready=1 -> addr sequence 0x0, 0x4, 0x8, ... with back-to-back requests; decode receives instr_pc 0x0, 0x4, 0x8 with matching data, in order.
- instr_ready=0, FIFO_DEPTH=4 -> exactly 4 pushes (PCs 0x0 to 0xC), then read_request=0. Raising instr_ready resumes fetch at addr 0x10 once a slot frees.
- branch_taken with target 0x100 while a request to 0x8 is outstanding, response 3 cycles later -> response data dropped, FIFO empty. Next request has addr=0x100 and the first instr_pc seen by decode is 0x100.
- branch_taken in the same cycle as read_response -> response not pushed, state IDLE, next addr=branch_target. branch_target=0x203 -> addr 0x200.
- PC wrap: RESET_VECTOR=32'hFFFF_FFFC -> addr sequence FFFF_FFFC, 0000_0000. Asserting reset mid-REQ -> outputs return to reset values and a late read_response is ignored.
- With FETCH_PERF_COUNTERS_EN: 5 instructions fetched with 2 wait cycles each -> fetch_count=5, stall_count=10.
